// File: rtl/riscv_rf_wb_sched_if.sv
// Bundles the write-back request ports, issue hazard check and regfile write port
// shared by the scheduler (slave) and its surrounding pipeline (master).
interface riscv_rf_wb_sched_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic                 p0_valid;
    logic [AW-1:0]        p0_rd;
    logic [XLEN-1:0]      p0_data;
    logic                 p0_ready;
    logic                 p1_valid;
    logic [AW-1:0]        p1_rd;
    logic [XLEN-1:0]      p1_data;
    logic                 p1_ready;
    logic                 iss_valid;
    logic                 iss_long;
    logic [AW-1:0]        iss_rs1;
    logic [AW-1:0]        iss_rs2;
    logic [AW-1:0]        iss_rd;
    logic                 iss_stall;
    logic                 we3;
    logic [AW-1:0]        a3;
    logic [XLEN-1:0]      wd3;
    logic [(1<<AW)-1:0]   pending;

    modport master (
        output p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
               iss_valid, iss_long, iss_rs1, iss_rs2, iss_rd,
        input  p0_ready, p1_ready, iss_stall, we3, a3, wd3, pending
    );

    modport slave (
        input  p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
               iss_valid, iss_long, iss_rs1, iss_rs2, iss_rd,
        output p0_ready, p1_ready, iss_stall, we3, a3, wd3, pending
    );
endinterface

// File: rtl/riscv_rf_wb_sched.sv
// Round-robin arbiter for the single regfile write port between the ALU (port 0)
// and LSU/MUL (port 1), plus a pending scoreboard stalling RAW/WAW on long ops.
module riscv_rf_wb_sched #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                clk,
    input  logic                rst,
    riscv_rf_wb_sched_if.slave  bus
);
    localparam int unsigned NREG = 1 << AW;

    typedef enum logic {
        LG_P0 = 1'b0,
        LG_P1 = 1'b1
    } lg_e;

    lg_e              lg_q, lg_d;
    logic             we_q, we_d;
    logic [AW-1:0]    a3_q, a3_d;
    logic [XLEN-1:0]  wd_q, wd_d;
    logic [NREG-1:0]  pend_q, pend_d;

    logic             p0_rdy, p1_rdy, xfer, stall, iss_set;
    logic [AW-1:0]    gnt_rd;
    logic [XLEN-1:0]  gnt_data;

    always_comb begin
        // The port that did not win last time gets priority on contention.
        p0_rdy   = bus.p0_valid & (~bus.p1_valid | (lg_q == LG_P1));
        p1_rdy   = bus.p1_valid & (~bus.p0_valid | (lg_q == LG_P0));
        xfer     = p0_rdy | p1_rdy;
        gnt_rd   = p1_rdy ? bus.p1_rd   : bus.p0_rd;
        gnt_data = p1_rdy ? bus.p1_data : bus.p0_data;

        stall   = bus.iss_valid & (pend_q[bus.iss_rs1] | pend_q[bus.iss_rs2] | pend_q[bus.iss_rd]);
        iss_set = bus.iss_valid & ~stall & bus.iss_long & (bus.iss_rd != '0);

        lg_d = lg_q;
        if (p0_rdy)      lg_d = LG_P0;
        else if (p1_rdy) lg_d = LG_P1;

        we_d = xfer & (gnt_rd != '0);
        a3_d = xfer ? gnt_rd   : a3_q;
        wd_d = xfer ? gnt_data : wd_q;

        // Clear is applied after set so it wins on a same-register collision.
        pend_d = pend_q;
        if (iss_set) pend_d[bus.iss_rd] = 1'b1;
        if (p1_rdy)  pend_d[bus.p1_rd]  = 1'b0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lg_q   <= LG_P1;
            we_q   <= 1'b0;
            a3_q   <= '0;
            wd_q   <= '0;
            pend_q <= '0;
        end else begin
            lg_q   <= lg_d;
            we_q   <= we_d;
            a3_q   <= a3_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
        end
    end

    assign bus.p0_ready  = p0_rdy;
    assign bus.p1_ready  = p1_rdy;
    assign bus.iss_stall = stall;
    assign bus.we3       = we_q;
    assign bus.a3        = a3_q;
    assign bus.wd3       = wd_q;
    assign bus.pending   = pend_q;
endmodule

// File: tb/tb_riscv_rf_wb_sched.sv
// Directed bench for riscv_rf_wb_sched: expected regfile writes are queued when a
// request is driven and checked one cycle later against we3/a3/wd3.
module tb_riscv_rf_wb_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
    } wr_t;

    wr_t         exp_q[$];
    logic [4:0]  hold_a3 = '0;
    logic [31:0] hold_wd = '0;

    always #5 clk = ~clk;

    riscv_rf_wb_sched_if #(.XLEN(32), .AW(5)) bus ();

    riscv_rf_wb_sched #(.XLEN(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_write();
        wr_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            chk("we3", {63'd0, bus.we3}, {63'd0, e.we});
            chk("a3",  {59'd0, bus.a3},  {59'd0, e.a3});
            chk("wd3", {32'd0, bus.wd3}, {32'd0, e.wd});
        end
    endtask

    // One clock with explicitly expected readies; the accepted request becomes
    // the expected write one cycle later.
    task automatic step(input logic e0, input logic e1);
        #1;
        chk("p0_ready", {63'd0, bus.p0_ready}, {63'd0, e0});
        chk("p1_ready", {63'd0, bus.p1_ready}, {63'd0, e1});
        if (e0) begin
            exp_q.push_back('{we: (bus.p0_rd != 0), a3: bus.p0_rd, wd: bus.p0_data});
            hold_a3 = bus.p0_rd;
            hold_wd = bus.p0_data;
        end else if (e1) begin
            exp_q.push_back('{we: (bus.p1_rd != 0), a3: bus.p1_rd, wd: bus.p1_data});
            hold_a3 = bus.p1_rd;
            hold_wd = bus.p1_data;
        end else begin
            exp_q.push_back('{we: 1'b0, a3: hold_a3, wd: hold_wd});
        end
        @(posedge clk);
        #1;
        pop_write();
    endtask

    task automatic rst_step();
        rst = 1'b1;
        #1;
        exp_q.push_back('{we: 1'b0, a3: 5'd0, wd: 32'd0});
        hold_a3 = '0;
        hold_wd = '0;
        @(posedge clk);
        #1;
        pop_write();
        rst = 1'b0;
    endtask

    task automatic chk_pend(input logic [31:0] exp);
        chk("pending", {32'd0, bus.pending}, {32'd0, exp});
    endtask

    task automatic chk_stall(input logic exp);
        #1;
        chk("iss_stall", {63'd0, bus.iss_stall}, {63'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.p0_valid = 0; bus.p0_rd = 0; bus.p0_data = 0;
        bus.p1_valid = 0; bus.p1_rd = 0; bus.p1_data = 0;
        bus.iss_valid = 0; bus.iss_long = 0;
        bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_rd = 0;

        rst_step();
        chk_pend(32'h0);

        // Single ALU write, then idle: a3/wd3 hold with we3 low.
        bus.p0_valid = 1; bus.p0_rd = 5; bus.p0_data = 32'hDEADBEEF;
        step(1'b1, 1'b0);
        bus.p0_valid = 0;
        step(1'b0, 1'b0);

        // Sustained contention after reset alternates p0,p1,p0,p1.
        rst_step();
        bus.p0_valid = 1; bus.p0_rd = 1; bus.p0_data = 32'h1111_0001;
        bus.p1_valid = 1; bus.p1_rd = 2; bus.p1_data = 32'h2222_0002;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        bus.p0_valid = 0; bus.p1_valid = 0;
        step(1'b0, 1'b0);

        // RAW: long op to x7, dependent issue stalls until the port-1 write of x7.
        bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 7; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
        chk_stall(1'b0);
        step(1'b0, 1'b0);
        chk_pend(32'h0000_0080);
        bus.iss_long = 0; bus.iss_rs1 = 7; bus.iss_rd = 10;
        chk_stall(1'b1);
        step(1'b0, 1'b0);
        chk_stall(1'b1);
        bus.p1_valid = 1; bus.p1_rd = 7; bus.p1_data = 32'h0000_7777;
        chk_stall(1'b1);
        step(1'b0, 1'b1);
        bus.p1_valid = 0;
        chk_pend(32'h0);
        chk_stall(1'b0);
        step(1'b0, 1'b0);
        chk_pend(32'h0);

        // WAW: second write to a pending register stalls.
        bus.iss_long = 1; bus.iss_rd = 12; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
        step(1'b0, 1'b0);
        chk_pend(32'h0000_1000);
        bus.iss_long = 0; bus.iss_rs2 = 0;
        chk_stall(1'b1);
        bus.iss_valid = 0;
        chk_stall(1'b0);
        bus.p1_valid = 1; bus.p1_rd = 12; bus.p1_data = 32'hC0C0_000C;
        step(1'b0, 1'b1);
        bus.p1_valid = 0;
        chk_pend(32'h0);

        // x0 destinations/operands never set pending nor stall.
        bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
        chk_stall(1'b0);
        step(1'b0, 1'b0);
        chk_pend(32'h0);
        bus.iss_long = 0; bus.iss_rd = 4;
        chk_stall(1'b0);
        step(1'b0, 1'b0);
        chk_pend(32'h0);
        bus.iss_valid = 0;

        // Port-1 transfer to x0 handshakes but never writes.
        bus.p1_valid = 1; bus.p1_rd = 0; bus.p1_data = 32'h0000_1234;
        step(1'b0, 1'b1);
        bus.p1_valid = 0;

        // Pending x3, ALU write to x3 leaves it pending; reset during an accepted request.
        bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 3;
        step(1'b0, 1'b0);
        bus.iss_valid = 0; bus.iss_long = 0;
        chk_pend(32'h0000_0008);
        bus.p0_valid = 1; bus.p0_rd = 3; bus.p0_data = 32'h3333_3333;
        step(1'b1, 1'b0);
        chk_pend(32'h0000_0008);
        bus.p0_rd = 9; bus.p0_data = 32'h9999_9999;
        #1;
        chk("p0_ready_in_rst", {63'd0, bus.p0_ready}, 64'd1);
        rst_step();
        chk_pend(32'h0);
        bus.p0_valid = 0;

        // Post-reset contention grants port 0 first.
        bus.p0_valid = 1; bus.p0_rd = 4; bus.p0_data = 32'h4444_0004;
        bus.p1_valid = 1; bus.p1_rd = 6; bus.p1_data = 32'h6666_0006;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        bus.p0_valid = 0; bus.p1_valid = 0;
        step(1'b0, 1'b0);

        chk("scoreboard_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_rf_wb_sched.md
Name: riscv_rf_wb_sched

Overview:
Write-back scheduler for the 32x32 two-read/one-write register file. It shares the single write port (we3/a3/wd3) between two requesters: the single-cycle ALU path (port 0) and the long-latency LSU/MUL path (port 1). It also keeps a per-register pending scoreboard for outstanding long-latency destinations, and stalls issue on RAW and WAW hazards against them. It sits between the execute units and the register file.

Parameters:
XLEN, 32, data width of write data
AW, 5, register address width (2^AW registers; x0 hardwired zero)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
p0_valid  in  1  ALU write-back request
p0_rd  in  AW  ALU destination register
p0_data  in  XLEN  ALU result
p0_ready  out  1  ALU request accepted this cycle
p1_valid  in  1  LSU/MUL write-back request
p1_rd  in  AW  LSU/MUL destination register
p1_data  in  XLEN  LSU/MUL result
p1_ready  out  1  LSU/MUL request accepted this cycle
iss_valid  in  1  instruction presented for issue
iss_long  in  1  instruction targets the LSU/MUL unit
iss_rs1  in  AW  source 1
iss_rs2  in  AW  source 2
iss_rd  in  AW  destination
iss_stall  out  1  issue must not proceed this cycle
we3  out  1  regfile write enable
a3  out  AW  regfile write address
wd3  out  XLEN  regfile write data
pending  out  2^AW  scoreboard bit vector (debug/verification)

Behaviour:
- Handshake: a transfer occurs when valid&ready are high on a rising edge. A requester holds valid, rd and data stable until accepted. Ready is combinational from both valids and the priority flag.
- Arbitration is round-robin with a 1-bit last-grant flag lg (reset 1, so port 0 wins the first contention).
  - Only one valid: that port gets ready=1.
  - Both valid: the port that is not lg gets ready; the other gets ready=0.
  - lg updates to the granted port on every transfer and holds when there is no transfer.
- Write port outputs are registered; latency is 1 cycle from transfer to write:
  - we3 <= transfer & (granted rd != 0)
  - a3 <= granted rd
  - wd3 <= granted data
  - When there is no transfer, we3 <= 0 and a3/wd3 hold.
  - A transfer with rd=0 completes the handshake but produces no write.
- Scoreboard, pending[0] is constant 0:
  - Set pending[iss_rd] on issue = iss_valid & !iss_stall & iss_long & iss_rd!=0.
  - Clear pending[p1_rd] on a port-1 transfer. The clear happens at the transfer edge (same edge as the we3 register update).
  - A single-cycle ALU issue never sets a bit.
- iss_stall = iss_valid & (pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd]), combinational from the current pending vector. It covers RAW and WAW.
  - x0 operands never stall.
  - A bit cleared on this edge stops stalling from the next cycle. No same-cycle bypass.
- Simultaneous set and clear of the same register cannot occur, because the WAW stall blocks it. The implementation must still give the clear priority if it does occur.
- A port-0 write to a register whose pending bit is set is legal (program order is guaranteed upstream). It does not alter pending.
- Reset:
  - we3=0, a3=0, wd3=0, pending=0, lg=1, p0_ready/p1_ready follow valids.
  - Reset mid-operation drops any in-flight registered write: we3=0 on the cycle after rst.
  - rst takes priority over all set/clear/transfer.

Test Plan:
- Reset then p0_valid=1, p0_rd=5, p0_data=0xDEADBEEF, p1_valid=0 -> p0_ready=1; next cycle we3=1, a3=5, wd3=0xDEADBEEF; the following cycle we3=0.
- Both valid for 4 cycles, p0_rd=1, p1_rd=2 (neither drops valid), with lg=1 after reset -> grants p0,p1,p0,p1; a3 sequence 1,2,1,2 each one cycle later.
- Issue long op rd=7 -> pending[7]=1. Then issue rs1=7 -> iss_stall=1 until p1 transfer with p1_rd=7. Stall deasserts the cycle after the transfer, and pending[7]=0.
- Issue long op with rd=0, and an ALU op with rs1=0 -> pending unchanged (all zero), iss_stall=0.
- p1 transfer with p1_rd=0, p1_data=0x1234 -> p1_ready=1; next cycle we3=0.
- Set pending[3], queue p0 request rd=9, assert rst for one cycle mid-stream -> the cycle after rst: we3=0, pending=0, wd3=0; the first post-reset contention grants port 0.
